// File: rtl/avalon_cmd_master.sv
// rtl/avalon_cmd_master.sv - valid/ready command port to single Avalon-MM transfers with waitrequest timeout
module avalon_cmd_master #(
  parameter int ADDR_WIDTH = 11,
  parameter int TIMEOUT    = 64
) (
  input  logic                  iClk,
  input  logic                  iReset,
  input  logic                  iCmdValid,
  output logic                  oCmdReady,
  input  logic                  iCmdWrite,
  input  logic [ADDR_WIDTH-1:0] iCmdAddress,
  input  logic [3:0]            iCmdByteenable,
  input  logic [31:0]           iCmdWritedata,
  output logic                  oRspValid,
  input  logic                  iRspReady,
  output logic [31:0]           oRspReaddata,
  output logic                  oRspError,
  output logic [7:0]            oErrCount,
  output logic [ADDR_WIDTH-1:0] avm_address,
  output logic [3:0]            avm_byteenable,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [31:0]           avm_writedata,
  input  logic [31:0]           avm_readdata,
  input  logic                  avm_waitrequest
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt;
  logic       cmd_write;
  logic       cmd_fire;
  logic       misaligned;
  logic       xfer_done;
  logic       timed_out;

  assign cmd_fire   = iCmdValid && (state == IDLE);
  assign misaligned = (iCmdAddress[1:0] != 2'b00);
  assign xfer_done  = (state == ACCESS) && !avm_waitrequest;
  assign timed_out  = (state == ACCESS) && avm_waitrequest && (wait_cnt == WAIT_LAST);

  always_ff @(posedge iClk) begin
    if (iReset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    oCmdReady = 1'b0;
    oRspValid = 1'b0;
    case (state)
      IDLE: begin
        oCmdReady = 1'b1;
        if (iCmdValid) state_nxt = misaligned ? RESP : ACCESS;
      end
      ACCESS: begin
        if (xfer_done || timed_out) state_nxt = RESP;
      end
      RESP: begin
        oRspValid = 1'b1;
        if (iRspReady) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus request, response payload, wait counter and error tally
  always_ff @(posedge iClk) begin
    if (iReset) begin
      avm_address    <= '0;
      avm_byteenable <= '0;
      avm_writedata  <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      cmd_write      <= 1'b0;
      wait_cnt       <= '0;
      oRspReaddata   <= '0;
      oRspError      <= 1'b0;
      oErrCount      <= '0;
    end else begin
      if (cmd_fire) begin
        avm_address    <= iCmdAddress;
        avm_byteenable <= iCmdByteenable;
        avm_writedata  <= iCmdWritedata;
        cmd_write      <= iCmdWrite;
        wait_cnt       <= '0;
        if (misaligned) begin
          oRspError    <= 1'b1;
          oRspReaddata <= '0;
          if (oErrCount != 8'hFF) oErrCount <= oErrCount + 8'd1;
        end else begin
          avm_write <= iCmdWrite;
          avm_read  <= !iCmdWrite;
        end
      end

      if (xfer_done) begin
        avm_read     <= 1'b0;
        avm_write    <= 1'b0;
        oRspReaddata <= cmd_write ? 32'h0 : avm_readdata;
        oRspError    <= 1'b0;
      end else if (timed_out) begin
        avm_read     <= 1'b0;
        avm_write    <= 1'b0;
        oRspReaddata <= '0;
        oRspError    <= 1'b1;
        if (oErrCount != 8'hFF) oErrCount <= oErrCount + 8'd1;
      end else if (state == ACCESS) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_avalon_cmd_master.sv
// tb/tb_avalon_cmd_master.sv - directed bench for avalon_cmd_master
`timescale 1ns/1ps
module tb_avalon_cmd_master;

  logic        iClk = 1'b0;
  logic        iReset;
  logic        iCmdValid;
  logic        oCmdReady;
  logic        iCmdWrite;
  logic [10:0] iCmdAddress;
  logic [3:0]  iCmdByteenable;
  logic [31:0] iCmdWritedata;
  logic        oRspValid;
  logic        iRspReady;
  logic [31:0] oRspReaddata;
  logic        oRspError;
  logic [7:0]  oErrCount;
  logic [10:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  avalon_cmd_master #(.ADDR_WIDTH(11), .TIMEOUT(64)) dut (
    .iClk(iClk), .iReset(iReset),
    .iCmdValid(iCmdValid), .oCmdReady(oCmdReady), .iCmdWrite(iCmdWrite),
    .iCmdAddress(iCmdAddress), .iCmdByteenable(iCmdByteenable), .iCmdWritedata(iCmdWritedata),
    .oRspValid(oRspValid), .iRspReady(iRspReady), .oRspReaddata(oRspReaddata),
    .oRspError(oRspError), .oErrCount(oErrCount),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable), .avm_read(avm_read),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  always #5 iClk = ~iClk;
  always @(posedge iClk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [10:0] a, input logic [3:0] be, input logic [31:0] wd);
    iCmdWrite      = wr;
    iCmdAddress    = a;
    iCmdByteenable = be;
    iCmdWritedata  = wd;
    iCmdValid      = 1'b1;
    tick();
    iCmdValid      = 1'b0;
  endtask

  // Plays the slave: stall for 'stall' cycles, then complete with rdata.
  task automatic run_access(input int stall, input logic [31:0] rdata, input logic [10:0] a,
                            output int hi, output logic stable);
    int left;
    hi     = 0;
    stable = 1'b1;
    left   = stall;
    for (int i = 0; i < 300 && (avm_read || avm_write); i++) begin
      hi++;
      if (avm_address !== a) stable = 1'b0;
      if (left > 0) begin
        avm_waitrequest = 1'b1;
        left--;
      end else begin
        avm_waitrequest = 1'b0;
        avm_readdata    = rdata;
      end
      tick();
    end
    avm_waitrequest = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   hi, t0, t1;
    logic stable, hold_ok, ready_low, no_rsp;

    iReset = 1'b1; iCmdValid = 1'b0; iCmdWrite = 1'b0; iCmdAddress = '0;
    iCmdByteenable = '0; iCmdWritedata = '0; iRspReady = 1'b1;
    avm_readdata = '0; avm_waitrequest = 1'b0;
    tick(); tick();
    chk("rst_read", avm_read, 0);
    chk("rst_write", avm_write, 0);
    chk("rst_addr", avm_address, 0);
    chk("rst_rspvalid", oRspValid, 0);
    chk("rst_rsperr", oRspError, 0);
    chk("rst_rspdata", oRspReaddata, 0);
    chk("rst_errcnt", oErrCount, 0);
    iReset = 1'b0;
    tick();
    chk("rst_cmdready", oCmdReady, 1);

    // zero-wait write
    issue(1'b1, 11'h004, 4'hF, 32'h1234_5678);
    t0 = cyc;
    chk("wr_write", avm_write, 1);
    chk("wr_read", avm_read, 0);
    chk("wr_addr", avm_address, 32'h004);
    chk("wr_data", avm_writedata, 32'h1234_5678);
    chk("wr_be", avm_byteenable, 4'hF);
    run_access(0, 32'h0, 11'h004, hi, stable);
    chk("wr_hi_cycles", hi, 1);
    chk("wr_rspvalid", oRspValid, 1);
    chk("wr_rsperr", oRspError, 0);
    chk("wr_rspdata", oRspReaddata, 0);
    chk("wr_cmdready_busy", oCmdReady, 0);
    tick();
    chk("wr_rsp_retired", oRspValid, 0);

    // zero-wait read, back to back
    issue(1'b0, 11'h004, 4'hF, 32'h0);
    t1 = cyc;
    chk("rd_period", t1 - t0, 3);
    chk("rd_read", avm_read, 1);
    run_access(0, 32'h1234_5678, 11'h004, hi, stable);
    chk("rd_hi_cycles", hi, 1);
    chk("rd_rspdata", oRspReaddata, 32'h1234_5678);
    chk("rd_rsperr", oRspError, 0);
    tick();

    // stalled read: 5 wait cycles
    issue(1'b0, 11'h008, 4'hF, 32'h0);
    run_access(5, 32'h0000_00AB, 11'h008, hi, stable);
    chk("stall_hi_cycles", hi, 6);
    chk("stall_addr_stable", stable, 1);
    chk("stall_rspvalid", oRspValid, 1);
    chk("stall_rspdata", oRspReaddata, 32'hAB);
    chk("stall_rsperr", oRspError, 0);
    chk("stall_errcnt", oErrCount, 0);
    tick();

    // timeout: slave never releases
    issue(1'b0, 11'h00C, 4'hF, 32'h0);
    t0 = cyc;
    run_access(1000, 32'hDEAD_BEEF, 11'h00C, hi, stable);
    chk("to_hi_cycles", hi, 64);
    chk("to_rsp_latency", cyc - t0, 64);
    chk("to_rspvalid", oRspValid, 1);
    chk("to_rsperr", oRspError, 1);
    chk("to_rspdata", oRspReaddata, 0);
    chk("to_errcnt", oErrCount, 1);
    tick();

    // next command after timeout
    issue(1'b0, 11'h00C, 4'h3, 32'h0);
    run_access(0, 32'h55AA_55AA, 11'h00C, hi, stable);
    chk("post_to_rspdata", oRspReaddata, 32'h55AA_55AA);
    chk("post_to_rsperr", oRspError, 0);
    chk("post_to_errcnt", oErrCount, 1);
    tick();

    // misaligned
    issue(1'b0, 11'h006, 4'hF, 32'h0);
    chk("mis_rspvalid", oRspValid, 1);
    chk("mis_noread", avm_read, 0);
    chk("mis_rsperr", oRspError, 1);
    chk("mis_rspdata", oRspReaddata, 0);
    chk("mis_errcnt", oErrCount, 2);
    tick();

    // response backpressure
    iRspReady = 1'b0;
    issue(1'b0, 11'h010, 4'hF, 32'h0);
    run_access(0, 32'hCAFE_BABE, 11'h010, hi, stable);
    hold_ok = 1'b1;
    ready_low = 1'b1;
    iCmdValid = 1'b1; iCmdWrite = 1'b1; iCmdAddress = 11'h020;
    avm_readdata = 32'h0BAD_0BAD;
    for (int i = 0; i < 10; i++) begin
      if (oRspValid !== 1'b1 || oRspReaddata !== 32'hCAFE_BABE || oRspError !== 1'b0) hold_ok = 1'b0;
      if (oCmdReady !== 1'b0 || avm_write !== 1'b0) ready_low = 1'b0;
      tick();
    end
    chk("bp_rsp_held", hold_ok, 1);
    chk("bp_cmdready_low", ready_low, 1);
    iCmdValid = 1'b0;
    iRspReady = 1'b1;
    tick();
    chk("bp_retired", oRspValid, 0);
    chk("bp_cmdready", oCmdReady, 1);

    // reset in the middle of ACCESS
    avm_waitrequest = 1'b1;
    issue(1'b0, 11'h014, 4'hF, 32'h0);
    tick();
    chk("mr_in_access", avm_read, 1);
    iReset = 1'b1;
    tick();
    chk("mr_read_drop", avm_read, 0);
    chk("mr_rspvalid", oRspValid, 0);
    iReset = 1'b0;
    avm_waitrequest = 1'b0;
    no_rsp = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (oRspValid !== 1'b0 || avm_read !== 1'b0) no_rsp = 1'b0;
    end
    chk("mr_no_rsp", no_rsp, 1);
    chk("mr_errcnt", oErrCount, 0);

    // error count saturation
    for (int i = 0; i < 260; i++) begin
      issue(1'b1, 11'h002, 4'hF, 32'h0);
      tick();
    end
    chk("sat_errcnt", oErrCount, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
